// File: rtl/mb_infix_writer.sv
// rtl/mb_infix_writer.sv - keypress stream to infix token writer with integer-to-float conversion
module mb_infix_writer #(
    parameter int MAX_DIGITS = 7,
    parameter int ADDR_W     = 9
) (
    input  logic              CLK_1MHz,
    input  logic              RSTN,
    input  logic              key_valid,
    input  logic [4:0]        key_code,
    output logic              key_ready,
    output logic              en_inf_w,
    output logic              we_inf,
    output logic [ADDR_W-1:0] addr_inf_w,
    output logic [35:0]       di_inf,
    output logic [ADDR_W-1:0] top_addr_inf,
    output logic              inf_start,
    output logic              input_error
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_CONV, S_WR_NUM, S_WR_OP, S_START, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         exp_q, exp_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [8:0]         op_q, op_d;
    logic               op_pend_q, op_pend_d;
    logic               eq_pend_q, eq_pend_d;
    logic               err_q, err_d;

    logic               ready_state;
    logic               accept;
    logic               is_digit, is_op, is_eq, is_clr;
    logic               ptr_full;
    logic [27:0]        acc_next;
    logic [8:0]         key_op;
    logic [31:0]        float_w;
    logic               wr_state;

    assign ready_state = (state_q == S_IDLE) || (state_q == S_ACCUM) || (state_q == S_DONE);
    assign accept      = key_valid && ready_state;
    assign is_digit    = (key_code <= 5'd9);
    assign is_op       = (key_code >= 5'd10) && (key_code <= 5'd15);
    assign is_eq       = (key_code == 5'd16);
    assign is_clr      = (key_code == 5'd17);
    assign ptr_full    = (ptr_q == {ADDR_W{1'b1}});
    // acc*10 + digit, formed as acc*8 + acc*2 + digit
    assign acc_next    = {1'b0, acc_q, 3'b000} + {3'b000, acc_q, 1'b0} + {23'd0, key_code};
    // Normalised operand: zero is special, otherwise the hidden bit sits in acc[23]
    assign float_w     = (acc_q == 24'd0) ? 32'h0000_0000 : {1'b0, exp_q, acc_q[22:0]};

    // Map operator key codes to the arranger's operator encoding
    always_comb begin
        key_op = 9'd0;
        case (key_code)
            5'd10:   key_op = 9'b1011_10000;
            5'd11:   key_op = 9'b1011_10001;
            5'd12:   key_op = 9'b1100_10000;
            5'd13:   key_op = 9'b1100_10001;
            5'd14:   key_op = 9'b1110_00000;
            5'd15:   key_op = 9'b1110_00001;
            default: key_op = 9'd0;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK_1MHz) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            acc_q     <= 24'd0;
            cnt_q     <= '0;
            exp_q     <= 8'd0;
            ptr_q     <= '0;
            op_q      <= 9'd0;
            op_pend_q <= 1'b0;
            eq_pend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            ptr_q     <= ptr_d;
            op_q      <= op_d;
            op_pend_q <= op_pend_d;
            eq_pend_q <= eq_pend_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath update for each key and conversion step
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        ptr_d     = ptr_q;
        op_d      = op_q;
        op_pend_d = op_pend_q;
        eq_pend_d = eq_pend_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    if (is_clr) begin
                        state_d   = S_IDLE;
                        acc_d     = 24'd0;
                        cnt_d     = '0;
                        ptr_d     = '0;
                        op_pend_d = 1'b0;
                        eq_pend_d = 1'b0;
                        err_d     = 1'b0;
                    end else if (is_digit) begin
                        if (cnt_q == CNT_W'(MAX_DIGITS)) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d   = acc_next[23:0];
                            cnt_d   = cnt_q + 1'b1;
                            state_d = S_ACCUM;
                        end
                    end else if (is_op) begin
                        op_d      = key_op;
                        op_pend_d = 1'b1;
                        exp_d     = 8'd150;
                        state_d   = (state_q == S_IDLE) ? S_WR_OP : S_CONV;
                    end else if (is_eq) begin
                        if (state_q == S_ACCUM) begin
                            eq_pend_d = 1'b1;
                            exp_d     = 8'd150;
                            state_d   = S_CONV;
                        end else begin
                            state_d = S_START;
                        end
                    end
                end
            end
            S_CONV: begin
                if ((acc_q == 24'd0) || acc_q[23]) begin
                    state_d = S_WR_NUM;
                end else begin
                    acc_d = {acc_q[22:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            S_WR_NUM: begin
                if (ptr_full) err_d = 1'b1;
                else          ptr_d = ptr_q + 1'b1;
                acc_d = 24'd0;
                cnt_d = '0;
                if (op_pend_q)      state_d = S_WR_OP;
                else if (eq_pend_q) state_d = S_START;
                else                state_d = S_IDLE;
            end
            S_WR_OP: begin
                if (ptr_full) err_d = 1'b1;
                else          ptr_d = ptr_q + 1'b1;
                op_pend_d = 1'b0;
                state_d   = S_IDLE;
            end
            S_START: begin
                if (ptr_q == '0) err_d = 1'b1;
                eq_pend_d = 1'b0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (accept && is_clr) begin
                    state_d   = S_IDLE;
                    acc_d     = 24'd0;
                    cnt_d     = '0;
                    ptr_d     = '0;
                    op_pend_d = 1'b0;
                    eq_pend_d = 1'b0;
                    err_d     = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; RSTN gates writes and start so reset aborts at once
    always_comb begin
        wr_state     = (state_q == S_WR_NUM) || (state_q == S_WR_OP);
        key_ready    = !RSTN || ready_state;
        en_inf_w     = 1'b0;
        we_inf       = 1'b0;
        addr_inf_w   = '0;
        di_inf       = 36'd0;
        inf_start    = RSTN && (state_q == S_START) && (ptr_q != '0);
        top_addr_inf = ptr_q;
        input_error  = err_q;
        if (RSTN && wr_state && !ptr_full) begin
            en_inf_w   = 1'b1;
            we_inf     = 1'b1;
            addr_inf_w = ptr_q + 1'b1;
            if (state_q == S_WR_NUM) di_inf = {4'b0000, float_w};
            else                     di_inf = {3'b000, 1'b1, 23'd0, op_q};
        end
    end

endmodule

// File: tb/tb_mb_infix_writer.sv
// tb/tb_mb_infix_writer.sv - directed-vector bench for mb_infix_writer
module tb_mb_infix_writer;

    logic        CLK_1MHz = 1'b0;
    logic        RSTN     = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code  = 5'd0;
    logic        key_ready;
    logic        en_inf_w;
    logic        we_inf;
    logic [8:0]  addr_inf_w;
    logic [35:0] di_inf;
    logic [8:0]  top_addr_inf;
    logic        inf_start;
    logic        input_error;

    logic [35:0] mem [0:511];
    int          wr_cnt    = 0;
    int          start_cnt = 0;
    int          n_vec     = 0;
    int          n_bad     = 0;

    localparam logic [4:0] K_ADD = 5'd10, K_MUL = 5'd12, K_LP = 5'd14,
                           K_RP = 5'd15, K_EQ = 5'd16, K_CLR = 5'd17;

    mb_infix_writer #(.MAX_DIGITS(7), .ADDR_W(9)) dut (
        .CLK_1MHz     (CLK_1MHz),
        .RSTN         (RSTN),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .en_inf_w     (en_inf_w),
        .we_inf       (we_inf),
        .addr_inf_w   (addr_inf_w),
        .di_inf       (di_inf),
        .top_addr_inf (top_addr_inf),
        .inf_start    (inf_start),
        .input_error  (input_error)
    );

    always #500 CLK_1MHz = ~CLK_1MHz;

    always @(negedge CLK_1MHz) begin
        if (en_inf_w && we_inf) begin
            mem[addr_inf_w] = di_inf;
            wr_cnt = wr_cnt + 1;
        end
        if (inf_start) start_cnt = start_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 512; i++) mem[i] = 36'hF_FFFF_FFFF;
        wr_cnt    = 0;
        start_cnt = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK_1MHz);
            #1;
        end
    endtask

    task automatic send_key(input logic [4:0] k);
        int guard;
        guard = 0;
        while (!key_ready && guard < 100) begin
            @(posedge CLK_1MHz);
            #1;
            guard++;
        end
        if (!key_ready) check("key_ready_timeout", 64'(key_ready), 64'd1);
        key_code  = k;
        key_valid = 1'b1;
        @(posedge CLK_1MHz);
        #1;
        key_valid = 1'b0;
    endtask

    initial begin
        clr_model();
        idle(3);
        check("rst_key_ready", 64'(key_ready), 64'd1);
        check("rst_en", 64'({en_inf_w, we_inf}), 64'd0);
        check("rst_start", 64'(inf_start), 64'd0);
        RSTN = 1'b1;
        idle(2);
        check("rst_top", 64'(top_addr_inf), 64'd0);
        check("rst_err", 64'(input_error), 64'd0);
        check("rst_addr_di", {19'd0, addr_inf_w, di_inf}, 64'd0);

        // 12 + 3 =
        clr_model();
        send_key(5'd1);
        send_key(5'd2);
        send_key(K_ADD);
        check("t1_ready_conv", 64'(key_ready), 64'd0);
        send_key(5'd3);
        send_key(K_EQ);
        check("t1_ready_conv2", 64'(key_ready), 64'd0);
        idle(40);
        check("t1_a1", 64'(mem[1]), 64'h0_4140_0000);
        check("t1_a2", 64'(mem[2]), 64'h1_0000_0170);
        check("t1_a3", 64'(mem[3]), 64'h0_4040_0000);
        check("t1_top", 64'(top_addr_inf), 64'd3);
        check("t1_starts", 64'(start_cnt), 64'd1);
        check("t1_writes", 64'(wr_cnt), 64'd3);
        check("t1_err", 64'(input_error), 64'd0);
        send_key(K_CLR);
        idle(2);
        check("t1_clr_top", 64'(top_addr_inf), 64'd0);

        // ( 0 ) * 7 =
        clr_model();
        send_key(K_LP);
        send_key(5'd0);
        send_key(K_RP);
        send_key(K_MUL);
        send_key(5'd7);
        send_key(K_EQ);
        idle(40);
        check("t2_a1", 64'(mem[1]), 64'h1_0000_01C0);
        check("t2_a2", 64'(mem[2]), 64'h0_0000_0000);
        check("t2_a3", 64'(mem[3]), 64'h1_0000_01C1);
        check("t2_a4", 64'(mem[4]), 64'h1_0000_0190);
        check("t2_a5", 64'(mem[5]), 64'h0_40E0_0000);
        check("t2_top", 64'(top_addr_inf), 64'd5);
        check("t2_starts", 64'(start_cnt), 64'd1);
        send_key(K_CLR);
        idle(2);

        // eight 9s, the last ignored
        clr_model();
        for (int i = 0; i < 8; i++) send_key(5'd9);
        check("t3_err_8th", 64'(input_error), 64'd1);
        send_key(K_EQ);
        idle(40);
        check("t3_a1", 64'(mem[1]), 64'h0_4B18_967F);
        check("t3_top", 64'(top_addr_inf), 64'd1);
        send_key(K_CLR);
        idle(2);
        check("t3_clr_err", 64'(input_error), 64'd0);

        // single digit 1: longest normalisation
        clr_model();
        send_key(5'd1);
        send_key(K_EQ);
        idle(40);
        check("t3b_a1", 64'(mem[1]), 64'h0_3F80_0000);
        send_key(K_CLR);
        idle(2);

        // '=' on empty buffer
        clr_model();
        send_key(K_EQ);
        idle(10);
        check("t4_starts", 64'(start_cnt), 64'd0);
        check("t4_err", 64'(input_error), 64'd1);
        send_key(K_CLR);
        idle(2);
        check("t4_clr_err", 64'(input_error), 64'd0);
        check("t4_clr_top", 64'(top_addr_inf), 64'd0);

        // reset during conversion
        clr_model();
        send_key(5'd5);
        send_key(K_EQ);
        check("t5_in_conv", 64'(key_ready), 64'd0);
        RSTN = 1'b0;
        @(posedge CLK_1MHz);
        #1;
        RSTN = 1'b1;
        idle(40);
        check("t5_writes", 64'(wr_cnt), 64'd0);
        check("t5_starts", 64'(start_cnt), 64'd0);
        check("t5_top", 64'(top_addr_inf), 64'd0);
        check("t5_ready", 64'(key_ready), 64'd1);

        // keys ignored in DONE until clear
        clr_model();
        send_key(5'd2);
        send_key(K_EQ);
        idle(40);
        check("t6_a1_first", 64'(mem[1]), 64'h0_4000_0000);
        clr_model();
        send_key(5'd4);
        send_key(K_ADD);
        idle(40);
        check("t6_done_writes", 64'(wr_cnt), 64'd0);
        check("t6_done_top", 64'(top_addr_inf), 64'd1);
        send_key(K_CLR);
        send_key(5'd4);
        send_key(K_EQ);
        idle(40);
        check("t6_a1", 64'(mem[1]), 64'h0_4080_0000);
        check("t6_top", 64'(top_addr_inf), 64'd1);
        check("t6_starts", 64'(start_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
